// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
//
// Multicycle sequencer for the single-issue RV32I core. Each instruction moves
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The module drives the
// enable strobes for the instruction register, PC, register file and data
// memory, and keeps cycle and retired-instruction counters.
//
// Parameters
//    CNT_W        width of cycle_cnt / instret_cnt (default 32)
//
// Ports
//    clk          sole clock, rising edge
//    rst          synchronous active-high reset
//    imem_ready   instruction memory presents a valid ir this cycle
//    dmem_ready   data access completes this cycle
//    dec_reg_we   decoder: instruction writes the register file
//    dec_is_load  decoder: load
//    dec_is_store decoder: store
//    dec_is_halt  decoder: halt
//    imem_req     fetch request
//    ir_we        latch the instruction register
//    dmem_req     data memory request
//    dmem_we      data request is a write (meaningful only with dmem_req)
//    rf_we        register file write strobe
//    pc_we        PC update strobe, also marks retirement
//    halted       core stopped
//    err          sticky: illegal load+store flag combination decoded
//    stage        current state code (FETCH=0 .. HALT=5)
//    cycle_cnt    cycles executed outside HALT
//    instret_cnt  instructions retired
// -----------------------------------------------------------------------------
module cpu_seq_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             dec_reg_we,
   input  logic             dec_is_load,
   input  logic             dec_is_store,
   input  logic             dec_is_halt,
   output logic             imem_req,
   output logic             ir_we,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             halted,
   output logic             err,
   output logic [2:0]       stage,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   state_t           state_reg, state_next;
   logic             ld_reg, st_reg, we_reg;
   logic             err_reg;
   logic [CNT_W-1:0] cycle_reg, instret_reg;
   logic             retire, err_set;

   // A decoded halt takes effect directly in DECODE, so only the load, store
   // and register-write flags need to survive into later states.

   always_comb begin
      state_next = state_reg;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      pc_we      = 1'b0;
      retire     = 1'b0;
      err_set    = 1'b0;

      case (state_reg)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we      = 1'b1;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_is_load && dec_is_store) begin
               err_set    = 1'b1;
               state_next = ST_HALT;
            end else if (dec_is_halt) begin
               // Halt retires without moving the PC.
               retire     = 1'b1;
               state_next = ST_HALT;
            end else begin
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_next = (ld_reg || st_reg) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = st_reg;
            if (dmem_ready) begin
               if (ld_reg) begin
                  state_next = ST_WB;
               end else begin
                  // Stores retire on the completing data cycle.
                  pc_we      = 1'b1;
                  retire     = 1'b1;
                  state_next = ST_FETCH;
               end
            end
         end
         ST_WB: begin
            rf_we      = we_reg;
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            // Codes 6 and 7 are unreachable; recover to FETCH.
            state_next = ST_FETCH;
         end
      endcase

      // Reset aborts the instruction in flight: no strobes, no retirement.
      if (rst) begin
         imem_req = 1'b0;
         ir_we    = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         rf_we    = 1'b0;
         pc_we    = 1'b0;
         retire   = 1'b0;
         err_set  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_FETCH;
         ld_reg      <= 1'b0;
         st_reg      <= 1'b0;
         we_reg      <= 1'b0;
         err_reg     <= 1'b0;
         cycle_reg   <= '0;
         instret_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_DECODE) begin
            ld_reg <= dec_is_load;
            st_reg <= dec_is_store;
            we_reg <= dec_reg_we;
         end
         if (err_set) begin
            err_reg <= 1'b1;
         end
         if (state_reg != ST_HALT) begin
            cycle_reg <= cycle_reg + CNT_W'(1);
         end
         if (retire) begin
            instret_reg <= instret_reg + CNT_W'(1);
         end
      end
   end

   assign halted      = (state_reg == ST_HALT);
   assign err         = err_reg;
   assign stage       = state_reg;
   assign cycle_cnt   = cycle_reg;
   assign instret_cnt = instret_reg;

endmodule
